// File: rtl/bcd_down_timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package bcd_down_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_e;

    // True when the nibble is a legal decimal digit.
    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD digit of the down counter; digits chain through borrow_in/borrow_out.
module bcd_down_digit
    import bcd_down_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    // Next digit value: load wins, otherwise decrement with 0 -> 9 wrap.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (borrow_in) begin
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
        end
    end

    // Digit register, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in && (digit_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Presettable BCD countdown timer with run/pause control, done pulse and optional auto-reload.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      tick,
    output logic [DIGIT_W*DIGITS-1:0] cnt,
    output logic                      busy,
    output logic                      zero,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned CNT_W = DIGIT_W * DIGITS;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] digit_load_val;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             load_ok;
    logic             digit_load;
    logic             dec_en;
    logic [DIGITS-1:0] borrow;
    logic             unused_borrow;

    // A load is accepted only if every nibble is a decimal digit.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_val[i*DIGIT_W +: DIGIT_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    // Digits reload from the preset on a load, else from the saved reload value.
    assign digit_load_val = load ? load_val : reload_q;
    assign borrow[0]      = dec_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic borrow_next;

        bcd_down_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .load      (digit_load),
            .load_digit(digit_load_val[i*DIGIT_W +: DIGIT_W]),
            .borrow_in (borrow[i]),
            .digit     (cnt[i*DIGIT_W +: DIGIT_W]),
            .borrow_out(borrow_next)
        );

        if (i < DIGITS - 1) begin : g_chain
            assign borrow[i+1] = borrow_next;
        end else begin : g_last
            // Decrement is never enabled at zero, so the final borrow cannot fire.
            assign unused_borrow = borrow_next;
        end
    end

    // Control FSM: inputs resolved in priority order load > start > pause > tick.
    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        err_d      = err_q;
        done_d     = 1'b0;
        digit_load = 1'b0;
        dec_en     = 1'b0;

        if (load) begin
            if (load_ok) begin
                digit_load = 1'b1;
                reload_d   = load_val;
                err_d      = 1'b0;
                state_d    = StIdle;
            end else begin
                err_d = 1'b1;
            end
        end else if (start) begin
            if ((state_q == StIdle && cnt != '0) || state_q == StPaused) begin
                state_d = StRun;
            end
        end else if (pause) begin
            if (state_q == StRun) begin
                state_d = StPaused;
            end
        end else if (tick && state_q == StRun) begin
            if (cnt != '0) begin
                dec_en = 1'b1;
                // BCD 1 is binary 1, so this decrement lands on zero.
                if (cnt == CNT_W'(1)) begin
                    done_d = 1'b1;
                    if (!AUTO_RELOAD) begin
                        state_d = StDone;
                    end
                end
            end else if (AUTO_RELOAD && reload_q != '0) begin
                digit_load = 1'b1;
            end else begin
                state_d = StDone;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            reload_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == StRun) || (state_q == StPaused);
    assign zero = (cnt == '0);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Presettable multi-digit BCD down counter with run/pause/done control, used as a countdown timer alongside the decade (up) counters.
- Loads a BCD start value and decrements by one on each qualified tick strobe, borrowing across decimal digits.
- Flags completion with a one-cycle done pulse.
- Optionally auto-reloads the last loaded value for periodic operation.

Parameters:
DIGITS, 2, number of BCD digits (count width = 4*DIGITS)
AUTO_RELOAD, 0, 1 = reload last valid load value on the tick after reaching zero; 0 = stop at zero

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
load  input  1  load load_val into count; aborts any run
load_val  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0]
start  input  1  begin/resume counting
pause  input  1  suspend counting
tick  input  1  count-enable strobe; one decrement per cycle high while running
cnt  output  4*DIGITS  current BCD count (registered)
busy  output  1  high in RUN or PAUSED
zero  output  1  high when cnt == 0 (decoded from register)
done  output  1  one-cycle pulse when count reaches zero
err  output  1  sticky: last load attempt had a digit > 9

Behaviour:
- Reset (rst low, asynchronous): cnt = 0, reload register = 0, state IDLE, busy = 0, zero = 1, done = 0, err = 0. Takes effect immediately, mid-run included.
- States: IDLE, RUN, PAUSED, DONE.
- Per-cycle input priority: load > start > pause > tick.
- load, any state, valid (all digits <= 9):
  - cnt and reload register take load_val next edge; err cleared; state -> IDLE.
- load, invalid (any digit > 9):
  - cnt, reload register and state unchanged; err = 1.
  - err stays set until the next valid load or reset.
- start:
  - IDLE with cnt != 0: -> RUN.
  - IDLE with cnt == 0: ignored.
  - PAUSED: -> RUN.
  - RUN and DONE: ignored.
- pause: RUN -> PAUSED. A tick in the same cycle is dropped. Ignored in other states.
- tick in RUN, cnt != 0: BCD decrement on that edge.
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - Example: 0x10 -> 0x09; 0x100 -> 0x099.
- tick in RUN, decrement yields 0: done = 1 for exactly the cycle where cnt first reads 0.
  - AUTO_RELOAD = 0: state -> DONE.
  - AUTO_RELOAD = 1: state stays RUN.
- tick in RUN, cnt == 0 (AUTO_RELOAD = 1 only):
  - cnt <= reload register, no done pulse.
  - If the reload register is 0: state -> DONE instead.
- tick outside RUN: ignored.
- DONE: cnt holds 0, busy = 0. Only load (or reset) leaves DONE.
- done is never high for two consecutive cycles. Latency tick -> cnt update is one edge.
- No wrap below zero: cnt never becomes all 9s.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, PAUSED, DONE)
  - BCD_MAX = 4'd9
  - digit width constant 4
  - function bcd_valid(digit)
- One natural sub-module, bcd_down_digit, instantiated DIGITS times in a borrow chain:
  - 4-bit register with async active-low reset.
  - Inputs: load, load digit, decrement enable (borrow_in).
  - Outputs: digit value; borrow_out = borrow_in && digit == 0.
- Top level holds the FSM, reload register, zero/done/err logic and load validation.

Test Plan:
1. Basic countdown, DIGITS=2, AUTO_RELOAD=0.
   - Stimulus: reset, load 0x25, start, then 25 ticks.
   - Required: cnt 0x25, 0x24 ... 0x20, 0x19 ... 0x00; done high exactly once, in the cycle cnt first reads 0x00; then busy = 0, state DONE; further ticks leave cnt = 0x00.
2. Borrow chain, DIGITS=3.
   - Stimulus: load 0x100, start, one tick.
   - Required: cnt = 0x099, done = 0.
3. Invalid load.
   - Stimulus: load 0x3A.
   - Required: err = 1, cnt unchanged.
   - Then load 0x12: err = 0, cnt = 0x12, state IDLE.
4. Pause/resume, and pause vs. tick.
   - Stimulus: load 0x05, start, 2 ticks (cnt = 0x03), assert pause together with a tick, then 3 more ticks.
   - Required: cnt stays 0x03, busy = 1.
   - Then start plus 3 ticks: cnt = 0x00, done pulse.
5. Auto-reload, AUTO_RELOAD=1.
   - Stimulus: load 0x02, start, 6 ticks.
   - Required: cnt 0x01, 0x00 (done), 0x02, 0x01, 0x00 (done), 0x02; state remains RUN.
6. Async reset mid-run.
   - Stimulus: load 0x40, start, 5 ticks (cnt = 0x35), drive rst low between clock edges.
   - Required: cnt = 0x00, busy = 0, zero = 1, err = 0 immediately, with no clock edge needed.
   - After release: start is ignored and the block stays IDLE.
